// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multicycle RV32I-subset core with shared memory port, register file and control FSM.
module multicycle_datapath #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            trap
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] TRAP     = 4'd11;

  logic [3:0]      state, dec_nxt;
  logic [31:0]     ir;
  logic [XLEN-1:0] oldpc, a, b, aluout, data, op2, alu_y, rf_wd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [XLEN-1:0] rf [0:31];
  logic [6:0]      op, f7;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic            f3_ok, r_ok, rf_we, lt;

  assign op = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Only add/slt/or/and encodings (plus sub in R-form) are legal.
  assign f3_ok = f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
  assign r_ok  = f3_ok && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));

  always_comb begin
    dec_nxt = (op == 7'h03 && f3 == 3'd2) ? MEMADR :
              (op == 7'h23 && f3 == 3'd2) ? MEMADR :
              (op == 7'h33 && r_ok)       ? EXECR  :
              (op == 7'h13 && f3_ok)      ? EXECI  :
              (op == 7'h63 && f3 == 3'd0) ? BEQ    :
              (op == 7'h6f)               ? JAL    : TRAP;
    op2   = state == EXECR ? b : imm_i;
    lt    = $signed(a) < $signed(op2);
    alu_y = f3 == 3'd2 ? {{(XLEN-1){1'b0}}, lt} :
            f3 == 3'd6 ? a | op2 :
            f3 == 3'd7 ? a & op2 :
            (state == EXECR && f7[5]) ? a - op2 : a + op2;
    rf_we = state == MEMWB || state == ALUWB || state == JAL;
    rf_wd = state == MEMWB ? data : state == ALUWB ? aluout : oldpc + XLEN'(4);
  end

  // Reset is folded in so an abandoned access drops mem_req at once.
  assign mem_req   = reset && (state == FETCH || state == MEMREAD || state == MEMWRITE);
  assign mem_we    = mem_req && state == MEMWRITE;
  assign mem_addr  = !mem_req ? '0 : state == FETCH ? pc : aluout;
  assign mem_wdata = mem_we ? b : '0;
  assign retire    = state == MEMWB || state == ALUWB || state == BEQ || state == JAL ||
                     (state == MEMWRITE && mem_ready);
  assign trap      = state == TRAP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      oldpc  <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      data   <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata[31:0];
          oldpc <= pc;
          pc    <= pc + XLEN'(4);
          state <= DECODE;
        end
        DECODE: begin
          a      <= rf[ir[19:15]];
          b      <= rf[ir[24:20]];
          aluout <= oldpc + imm_b;
          state  <= dec_nxt;
        end
        MEMADR: begin
          aluout <= a + (ir[5] ? imm_s : imm_i);
          state  <= ir[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: if (mem_ready) begin
          data  <= mem_rdata;
          state <= MEMWB;
        end
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR, EXECI: begin
          aluout <= alu_y;
          state  <= ALUWB;
        end
        BEQ: begin
          if (a == b) pc <= aluout;
          state <= FETCH;
        end
        JAL: begin
          pc    <= oldpc + imm_j;
          state <= FETCH;
        end
        MEMWB, ALUWB: state <= FETCH;
        default: state <= state;
      endcase
      if (rf_we && rd != 5'd0) rf[rd] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed program runs on a 32-bit core at 0x100 and a 64-bit core for mid-access reset.
module tb_multicycle_datapath;
  localparam int DW = 3;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic        req_a, we_a, retire_a, trap_a;
  logic [31:0] addr_a, wdata_a, pc_a;
  logic        ready_a = 1'b0;
  logic [31:0] rdata_a = '0;
  logic        req_b, we_b, retire_b, trap_b;
  logic [63:0] addr_b, wdata_b, pc_b;
  logic        ready_b;
  logic [63:0] rdata_b;
  logic [31:0] dmem [0:15];
  int          cnt = 0;
  int          compared = 0, failed = 0;
  int          wcyc, wbad = 0;

  always #5 clk = ~clk;

  multicycle_datapath #(.XLEN(32), .RESET_PC(32'h100)) dut_a (
    .clk(clk), .reset(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ready(ready_a), .pc(pc_a),
    .retire(retire_a), .trap(trap_a));

  multicycle_datapath #(.XLEN(64)) dut_b (
    .clk(clk), .reset(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(ready_b), .pc(pc_b),
    .retire(retire_b), .trap(trap_b));

  function automatic logic [31:0] prog(input logic [31:0] adr);
    case (adr)
      32'h100: prog = 32'h00500093; // addi x1,x0,5
      32'h104: prog = 32'hFFD00113; // addi x2,x0,-3
      32'h108: prog = 32'h002081B3; // add  x3,x1,x2
      32'h10C: prog = 32'h00112233; // slt  x4,x2,x1
      32'h110: prog = 32'h401102B3; // sub  x5,x2,x1
      32'h114: prog = 32'h0020F4B3; // and  x9,x1,x2
      32'h118: prog = 32'h0020E533; // or   x10,x1,x2
      32'h11C: prog = 32'h0F017593; // andi x11,x2,0xf0
      32'h120: prog = 32'h1000E613; // ori  x12,x1,0x100
      32'h124: prog = 32'hFFE12693; // slti x13,x2,-2
      32'h128: prog = 32'h0050A713; // slti x14,x1,5
      32'h12C: prog = 32'h00102423; // sw   x1,8(x0)
      32'h130: prog = 32'h00802303; // lw   x6,8(x0)
      32'h134: prog = 32'h00108863; // beq  x1,x1,+16
      32'h144: prog = 32'h00208863; // beq  x1,x2,+16
      32'h148: prog = 32'h010003EF; // jal  x7,+16
      32'h158: prog = 32'hFF9FF46F; // jal  x8,-8
      32'h150: prog = 32'h00900013; // addi x0,x0,9
      32'h154: prog = 32'hFFFFFFFF;
      default: prog = 32'h00000013;
    endcase
  endfunction

  // Memory model for core A: fetches are zero-wait, data accesses take DW wait cycles.
  always @(negedge clk) begin
    if (ready_a) begin
      ready_a = 1'b0;
      cnt = 0;
    end
    if (req_a) begin
      if (cnt >= (addr_a < 32'h100 ? DW : 0)) begin
        ready_a = 1'b1;
        if (we_a) dmem[addr_a[5:2]] = wdata_a;
        else rdata_a = addr_a < 32'h100 ? dmem[addr_a[5:2]] : prog(addr_a);
      end else cnt++;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_retire(output int n, output logic [31:0] fa);
    n = 0;
    fa = '0;
    wcyc = 0;
    do begin
      tick;
      n++;
      if (n == 1) fa = addr_a;
      if (req_a && we_a) begin
        wcyc++;
        if (addr_a !== 32'h8 || wdata_a !== 32'h5) wbad++;
      end
    end while (!retire_a && n < 40);
  endtask

  logic [31:0] ea [0:17] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
                             32'h11C, 32'h120, 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134,
                             32'h144, 32'h148, 32'h158, 32'h150};
  int          ec [0:17] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 7, 8, 3, 3, 3, 3, 4};
  int          ew [0:17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0};
  logic [31:0] erf [0:14] = '{32'h0, 32'h5, 32'hFFFFFFFD, 32'h2, 32'h1, 32'hFFFFFFF8, 32'h5,
                              32'h14C, 32'h15C, 32'h5, 32'hFFFFFFFD, 32'hF0, 32'h105, 32'h1, 32'h0};

  initial begin
    int n;
    logic [31:0] fa;
    ready_b = 1'b0;
    rdata_b = '0;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    repeat (2) tick;
    chk("rst_req", req_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_we_wdata", {we_a, wdata_a}, 0);
    chk("rst_pc", pc_a, 32'h100);
    chk("rst_retire_trap", {retire_a, trap_a}, 0);
    chk("rst_b_outs", {req_b, we_b, retire_b, trap_b, addr_b, wdata_b, pc_b}, 0);
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1;
    chk("first_fetch", {req_a, we_a, addr_a}, {2'b10, 32'h100});
    for (int i = 0; i < 18; i++) begin
      wait_retire(n, fa);
      chk($sformatf("fetch_addr[%0d]", i), fa, ea[i]);
      chk($sformatf("cycles[%0d]", i), n, ec[i]);
      chk($sformatf("write_cycles[%0d]", i), wcyc, ew[i]);
    end
    chk("sw_held_stable", wbad, 0);
    tick;
    chk("illegal_fetch", {req_a, addr_a}, {1'b1, 32'h154});
    tick;
    chk("decode_no_retire", retire_a, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("trap_hold", {trap_a, req_a, retire_a}, 3'b100);
    end
    for (int i = 0; i < 15; i++) chk($sformatf("x%0d", i), dut_a.rf[i], erf[i]);
    chk("dmem_word2", dmem[2], 32'h5);
    rst_a = 1'b0;
    #1;
    chk("trap_cleared", {trap_a, req_a}, 0);
    chk("rf_cleared", dut_a.rf[1], 0);
    chk("pc_restart", pc_a, 32'h100);
    @(posedge clk);
    #1 rst_a = 1'b1;
    wait_retire(n, fa);
    chk("restart_fetch", fa, 32'h100);
    chk("restart_cycles", n, 4);

    @(posedge clk);
    #1 rst_b = 1'b1;
    tick;
    chk("b_fetch0", {req_b, addr_b}, {1'b1, 64'h0});
    rdata_b = {32'h12345678, 32'hFFF00093};
    ready_b = 1'b1;
    tick;
    ready_b = 1'b0;
    tick;
    tick;
    chk("b_retire1", retire_b, 1);
    tick;
    chk("b_fetch4", {req_b, addr_b}, {1'b1, 64'h4});
    rdata_b = {32'h0, 32'h00802303};
    ready_b = 1'b1;
    tick;
    ready_b = 1'b0;
    tick;
    tick;
    chk("b_memread", {req_b, we_b, addr_b}, {2'b10, 64'h8});
    chk("b_x1_ones", dut_b.rf[1], 64'hFFFF_FFFF_FFFF_FFFF);
    tick;
    rst_b = 1'b0;
    #1;
    chk("b_abort_req", req_b, 0);
    chk("b_abort_regs", {dut_b.rf[1], pc_b}, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    tick;
    chk("b_refetch", {req_b, addr_b}, {1'b1, 64'h0});
    rdata_b = {32'h12345678, 32'hFFF00093};
    ready_b = 1'b1;
    tick;
    ready_b = 1'b0;
    tick;
    tick;
    chk("b_retire2", retire_b, 1);
    tick;
    chk("b_x1_after", dut_b.rf[1], 64'hFFFF_FFFF_FFFF_FFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multicycle RV32I-subset processor core: datapath, internal 32-entry register file and main control FSM in one block, behind a single unified instruction/data memory port with a req/ready handshake. It is the successor to the single-cycle datapath. Each instruction runs over 3–5 states so one memory and one ALU are shared, memory may insert wait states, and undecodable instructions halt the core in a sticky trap. It sits between the memory subsystem and the top-level SoC wrapper.

## Interface
- XLEN, 32: datapath/register width; legal values 32 or 64. Instructions are always 32 bits.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  XLEN  byte address of the word access
- mem_wdata  out  XLEN  store data; valid while mem_req=1 and mem_we=1
- mem_rdata  in  XLEN  read data; sampled in the cycle mem_ready=1
- mem_ready  in  1  completes the current request in the cycle it is high
- pc  out  XLEN  current PC register
- retire  out  1  single-cycle pulse in the final state of each completed instruction
- trap  out  1  sticky illegal-instruction flag

## Operation
- Supported instructions: lw, sw; add, sub, and, or, slt; addi, andi, ori, slti; beq; jal. Any other opcode or funct combination goes to TRAP.
- Internal registers: PC, OldPC, IR, A, B, ALUOut, Data, state, and regs x1..x31. x0 reads 0 and ignores writes.
- All arithmetic is modulo 2^XLEN. slt/slti compare signed. Immediates are sign-extended from the instruction to XLEN.
- For XLEN=64, fetch uses mem_rdata[31:0].
- FSM states and actions:
  - FETCH:
    - mem_req=1, mem_we=0, mem_addr=PC.
    - On mem_ready: IR<=mem_rdata, OldPC<=PC, PC<=PC+4, go to DECODE. Otherwise stay in FETCH.
  - DECODE:
    - A<=rs1, B<=rs2, ALUOut<=OldPC+immB.
    - Next state by opcode: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, beq→BEQ, jal→JAL, else→TRAP.
  - MEMADR: ALUOut<=A+imm (I-imm for lw, S-imm for sw); next MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: mem_req=1, mem_we=0, mem_addr=ALUOut; on mem_ready, Data<=mem_rdata and go to MEMWB.
  - MEMWB: rd<=Data; retire=1; go to FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B; on mem_ready, retire=1 and go to FETCH.
  - EXECR / EXECI: ALUOut<=A op B, or A op immI; go to ALUWB.
  - ALUWB: rd<=ALUOut; retire=1; go to FETCH.
  - BEQ: if A==B then PC<=ALUOut; retire=1; go to FETCH.
  - JAL: PC<=OldPC+immJ, rd<=OldPC+4; retire=1; go to FETCH.
  - TRAP: trap=1, mem_req=0. No state updates; leave only via reset.

## Timing
- Reset (asynchronous, while reset=0):
  - state=FETCH, PC=RESET_PC, all regs and internal registers = 0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, trap=0.
- mem_req is high from the first FETCH cycle after reset is released.
- Handshake:
  - While mem_req=1, mem_we/mem_addr/mem_wdata stay stable until the cycle mem_ready=1.
  - Zero-wait (mem_ready already high) completes in one cycle.
  - mem_ready while mem_req=0 is ignored.
- mem_req is combinational from state and high only in FETCH, MEMREAD and MEMWRITE. All other outputs are registered or decoded from state.
- Cycles per instruction with zero wait: R/I-ALU 4, lw 5, sw 4, beq 3, jal 3. Each wait cycle adds one.
- A register written in cycle n is read correctly by DECODE of the next instruction; no bypass is needed, since FETCH always intervenes.
- Reset asserted mid-access drops mem_req immediately; the access is abandoned.
- A rd=x0 write has no effect but still retires.
- A branch or jump to a misaligned target is not checked.

## Test plan
- Reset and first fetch: release reset with RESET_PC=0x100 → first cycle has mem_req=1, mem_addr=0x100, mem_we=0; pc=0x100.
- ALU sequence, zero wait: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1; sub x5,x2,x1 → x3=2, x4=1, x5=0xFFFFFFF8; each retire pulse 4 cycles apart.
- Load/store with waits: sw x1,8(x0) with mem_ready delayed 3 cycles → addr/wdata 0x8/5 held stable throughout. Then lw x6,8(x0) returning 5 → x6=5; lw retire 5+waits cycles after its fetch.
- Branches and jumps:
  - beq x1,x1,+16 at 0x20 → next fetch 0x30.
  - Not-taken beq → next fetch 0x24.
  - jal x7,-8 at 0x40 → x7=0x44, next fetch 0x38.
  - addi x0,x0,9 → x0 stays 0.
- Illegal instruction: fetch 0xFFFFFFFF → after DECODE, trap=1 and mem_req=0 forever; no retire. Asserting reset clears trap and restarts at RESET_PC.
- Mid-access reset with XLEN=64: assert reset during a MEMREAD wait → mem_req=0 immediately, regs=0; after release, addi x1,x0,-1 gives x1=0xFFFFFFFFFFFFFFFF.
